// File: rtl/usb_fe_stream_source.sv
// Front-end byte-stream generator: replays a latched pattern as framed captures
// on the fe_data / fe_data_valid / capturing interface, MSB byte first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// LEAD  | one capturing-high cycle before the first byte of a frame
// BYTE  | one valid strobe carrying the current pattern byte
// GAP   | capturing high, valid low between bytes of a frame
// TAIL  | one capturing-high cycle after the last byte of a frame
// FGAP  | capturing low between frames (at least one cycle)
// DONE  | one-cycle completion pulse, then back to IDLE
module usb_fe_stream_source #(
    parameter int pPATTERN_BYTES = 8
) (
    input  logic                        fe_clk,
    input  logic                        reset_i,
    input  logic                        I_start,
    input  logic                        I_abort,
    input  logic [pPATTERN_BYTES*8-1:0] I_pattern,
    input  logic [7:0]                  I_pattern_bytes,
    input  logic [7:0]                  I_gap,
    input  logic [15:0]                 I_frame_gap,
    input  logic [7:0]                  I_repeat,
    output logic [7:0]                  O_fe_data,
    output logic                        O_fe_data_valid,
    output logic                        O_capturing,
    output logic                        O_busy,
    output logic                        O_done
);

    localparam int IDXW = (pPATTERN_BYTES > 1) ? $clog2(pPATTERN_BYTES) : 1;
    localparam logic [7:0] MAX_BYTES = 8'(pPATTERN_BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_BYTE = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_TAIL = 3'd4;
    localparam logic [2:0] S_FGAP = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]                  state, state_d;
    logic [pPATTERN_BYTES*8-1:0] pat_q;
    logic [7:0]                  gap_q;
    logic [15:0]                 fg_q;
    logic [IDXW-1:0]             first_idx_q;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic [7:0]                  gcnt_q, gcnt_d;
    logic [15:0]                 fcnt_q, fcnt_d;
    logic [7:0]                  frm_q, frm_d;
    logic [7:0]                  nc_in;
    logic [7:0]                  data_d;
    logic                        latch;

    assign nc_in = (I_pattern_bytes > MAX_BYTES) ? MAX_BYTES : I_pattern_bytes;

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        fcnt_d  = fcnt_q;
        frm_d   = frm_q;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_start && !I_abort) begin
                    latch   = 1'b1;
                    frm_d   = I_repeat;
                    idx_d   = IDXW'(nc_in - 8'd1);
                    state_d = (nc_in == 8'd0) ? S_DONE : S_LEAD;
                end
            end
            S_LEAD: state_d = S_BYTE;
            S_BYTE: begin
                if (idx_q == '0) begin
                    state_d = S_TAIL;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                    if (gap_q != 8'd0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q - 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == 8'd0) state_d = S_BYTE;
                else                gcnt_d  = gcnt_q - 8'd1;
            end
            S_TAIL: begin
                if (frm_q != 8'd0) begin
                    state_d = S_FGAP;
                    frm_d   = frm_q - 8'd1;
                    // zero frame gap still gets one capturing-low cycle
                    fcnt_d  = (fg_q == 16'd0) ? 16'd0 : fg_q - 16'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FGAP: begin
                if (fcnt_q == 16'd0) begin
                    state_d = S_LEAD;
                    idx_d   = first_idx_q;
                end else begin
                    fcnt_d = fcnt_q - 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (I_abort && state != S_IDLE) state_d = S_IDLE;
    end

    // data tracks the byte about to be presented; holds otherwise
    assign data_d = (state_d == S_BYTE) ? pat_q[{idx_d, 3'b000} +: 8] : O_fe_data;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state           <= S_IDLE;
            pat_q           <= '0;
            gap_q           <= '0;
            fg_q            <= '0;
            first_idx_q     <= '0;
            idx_q           <= '0;
            gcnt_q          <= '0;
            fcnt_q          <= '0;
            frm_q           <= '0;
            O_fe_data       <= '0;
            O_fe_data_valid <= 1'b0;
            O_capturing     <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
        end else begin
            state  <= state_d;
            idx_q  <= idx_d;
            gcnt_q <= gcnt_d;
            fcnt_q <= fcnt_d;
            frm_q  <= frm_d;
            if (latch) begin
                pat_q       <= I_pattern;
                gap_q       <= I_gap;
                fg_q        <= I_frame_gap;
                first_idx_q <= IDXW'(nc_in - 8'd1);
            end
            O_fe_data       <= data_d;
            O_fe_data_valid <= (state_d == S_BYTE);
            O_capturing     <= (state_d == S_LEAD) || (state_d == S_BYTE) ||
                               (state_d == S_GAP)  || (state_d == S_TAIL);
            O_busy          <= (state_d != S_IDLE) && (state_d != S_DONE);
            O_done          <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_usb_fe_stream_source.sv
// Directed bench for usb_fe_stream_source: per-cycle output bitmaps and byte
// sequences compared against hand-derived timelines.
module tb_usb_fe_stream_source;

    logic        fe_clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        I_start = 1'b0;
    logic        I_abort = 1'b0;
    logic [63:0] I_pattern = 64'h1122_3344_55AA_BBCC;
    logic [7:0]  I_pattern_bytes = 8'd3;
    logic [7:0]  I_gap = 8'd0;
    logic [15:0] I_frame_gap = 16'd0;
    logic [7:0]  I_repeat = 8'd0;
    logic [7:0]  O_fe_data;
    logic        O_fe_data_valid;
    logic        O_capturing;
    logic        O_busy;
    logic        O_done;

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_m, val_m, bsy_m, dn_m;
    logic [7:0]  last_dat;
    logic [7:0]  bytes_q[$];

    usb_fe_stream_source #(.pPATTERN_BYTES(8)) dut (
        .fe_clk          (fe_clk),
        .reset_i         (reset_i),
        .I_start         (I_start),
        .I_abort         (I_abort),
        .I_pattern       (I_pattern),
        .I_pattern_bytes (I_pattern_bytes),
        .I_gap           (I_gap),
        .I_frame_gap     (I_frame_gap),
        .I_repeat        (I_repeat),
        .O_fe_data       (O_fe_data),
        .O_fe_data_valid (O_fe_data_valid),
        .O_capturing     (O_capturing),
        .O_busy          (O_busy),
        .O_done          (O_done)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // expected bytes packed first-sent in the most significant position
    task automatic check_bytes(input string tag, input logic [63:0] exp, input int n);
        logic [7:0] got;
        check({tag, "_count"}, 64'(bytes_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), 64'(got), 64'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    // start is high during cycle 0; cycles 1..n are recorded
    task automatic run(input int n, input int mid_start, input int abort_at, input int reset_at);
        cap_m = '0; val_m = '0; bsy_m = '0; dn_m = '0;
        bytes_q.delete();
        @(negedge fe_clk);
        I_start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(posedge fe_clk);
            #1;
            cap_m[c] = O_capturing;
            val_m[c] = O_fe_data_valid;
            bsy_m[c] = O_busy;
            dn_m[c]  = O_done;
            if (O_fe_data_valid) bytes_q.push_back(O_fe_data);
            last_dat = O_fe_data;
            I_start  = (c == mid_start);
            I_abort  = (c == abort_at);
            reset_i  = (c == reset_at);
            if (c == mid_start) I_pattern_bytes = 8'd1;
        end
        I_start = 1'b0;
        I_abort = 1'b0;
        reset_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge fe_clk);
        #1;
        check("rst_data", 64'(O_fe_data), 64'h0);
        check("rst_valid", 64'(O_fe_data_valid), 64'h0);
        check("rst_capturing", 64'(O_capturing), 64'h0);
        check("rst_busy", 64'(O_busy), 64'h0);
        check("rst_done", 64'(O_done), 64'h0);
        reset_i = 1'b0;
        repeat (2) @(posedge fe_clk);

        // single frame, N=3, gap=0
        I_pattern_bytes = 8'd3; I_gap = 8'd0; I_repeat = 8'd0; I_frame_gap = 16'd0;
        run(8, 0, 0, 0);
        check("t1_cap", cap_m, 64'h3E);
        check("t1_valid", val_m, 64'h1C);
        check("t1_busy", bsy_m, 64'h3E);
        check("t1_done", dn_m, 64'h40);
        check_bytes("t1", 64'hAABBCC, 3);
        check("t1_hold", 64'(last_dat), 64'hCC);

        // gap=2
        I_pattern_bytes = 8'd3; I_gap = 8'd2;
        run(12, 0, 0, 0);
        check("t2_valid", val_m, 64'h124);
        check("t2_cap", cap_m, 64'h3FE);
        check("t2_done", dn_m, 64'h400);
        check_bytes("t2", 64'hAABBCC, 3);

        // three frames of N=2, frame_gap=0
        I_pattern_bytes = 8'd2; I_gap = 8'd0; I_repeat = 8'd2; I_frame_gap = 16'd0;
        run(18, 0, 0, 0);
        check("t3_cap", cap_m, 64'h7BDE);
        check("t3_valid", val_m, 64'h318C);
        check("t3_done", dn_m, 64'h8000);
        check_bytes("t3", 64'hBBCC_BBCC_BBCC, 6);

        // two frames of N=1, frame_gap=3
        I_pattern_bytes = 8'd1; I_repeat = 8'd1; I_frame_gap = 16'd3;
        run(12, 0, 0, 0);
        check("t3b_cap", cap_m, 64'h38E);
        check("t3b_valid", val_m, 64'h104);
        check("t3b_done", dn_m, 64'h400);

        // N clamps to 8
        I_pattern_bytes = 8'd12; I_repeat = 8'd0; I_frame_gap = 16'd0;
        run(14, 0, 0, 0);
        check_bytes("t4", 64'h1122_3344_55AA_BBCC, 8);
        check("t4_done", dn_m, 64'h800);

        // N=0 completes immediately
        I_pattern_bytes = 8'd0;
        run(4, 0, 0, 0);
        check("t4z_done", dn_m, 64'h2);
        check("t4z_cap", cap_m, 64'h0);
        check("t4z_valid", val_m, 64'h0);
        check("t4z_busy", bsy_m, 64'h0);

        // abort in second GAP cycle of gap=3 frame
        I_pattern_bytes = 8'd3; I_gap = 8'd3;
        run(6, 0, 4, 0);
        check("t5_cap", cap_m, 64'h1E);
        check("t5_valid", val_m, 64'h4);
        check("t5_busy", bsy_m, 64'h1E);
        check("t5_done", dn_m, 64'h0);

        // restart accepted; start while busy ignored
        I_pattern_bytes = 8'd3; I_gap = 8'd3;
        run(14, 3, 0, 0);
        check("t5r_valid", val_m, 64'h444);
        check("t5r_done", dn_m, 64'h1000);
        check_bytes("t5r", 64'hAABBCC, 3);

        // reset mid-frame
        I_pattern_bytes = 8'd3; I_gap = 8'd2;
        run(8, 0, 0, 3);
        check("t6_cap", cap_m, 64'hE);
        check("t6_valid", val_m, 64'h4);
        check("t6_busy", bsy_m, 64'hE);
        check("t6_done", dn_m, 64'h0);
        check("t6_data", 64'(last_dat), 64'h0);

        // start and abort together in IDLE
        I_pattern_bytes = 8'd3; I_gap = 8'd0;
        I_abort = 1'b1;
        run(6, 0, 0, 0);
        check("t6sa_cap", cap_m, 64'h0);
        check("t6sa_valid", val_m, 64'h0);
        check("t6sa_busy", bsy_m, 64'h0);
        check("t6sa_done", dn_m, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
